// File: rtl/sensor_scan.sv
// sensor_scan: time-multiplexed sensor front end.
// Steps the external mux select through four sensors, lets the line settle,
// debounces each reading (with a fail-safe timeout) and publishes the four
// results atomically with a one-cycle valid strobe.
// Optional feature macro: SENSOR_ERROR_EN (registered error decode of the
// published vector); when undefined the error port is tied low.
module sensor_scan #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_COUNT = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_start,
    input  logic       sense_in,
    output logic [1:0] sel,
    output logic [3:0] sensors,
    output logic       sensors_valid,
    output logic       busy,
    output logic       timeout_flag,
    output logic       error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    DEB_TARGET  = 4'(DEBOUNCE_COUNT);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q,   state_d;
    logic [1:0]    idx_q,     idx_d;
    logic [3:0]    settle_q,  settle_d;
    logic [3:0]    match_q,   match_d;
    logic          cand_q,    cand_d;
    logic [TW-1:0] samp_q,    samp_d;
    logic [3:0]    shadow_q,  shadow_d;
    logic [3:0]    sensors_q, sensors_d;
    logic          tmo_q,     tmo_d;
    logic          valid_q;
    logic          busy_q;
    logic          accept_s;
    logic          expire_s;

    // Next-state logic: scan sequencing, debounce and fail-safe timeout
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        match_d   = match_q;
        cand_d    = cand_q;
        samp_d    = samp_q;
        shadow_d  = shadow_q;
        sensors_d = sensors_q;
        tmo_d     = tmo_q;
        accept_s  = 1'b0;
        expire_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    state_d  = S_SETTLE;
                    idx_d    = 2'd0;
                    settle_d = 4'd0;
                    match_d  = 4'd0;
                    samp_d   = '0;
                    shadow_d = 4'd0;
                    tmo_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = S_SAMPLE;
                    settle_d = 4'd0;
                    match_d  = 4'd0;
                    samp_d   = '0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                // A fresh or differing sample restarts the run of equal samples
                if ((match_q == 4'd0) || (sense_in != cand_q)) begin
                    cand_d  = sense_in;
                    match_d = 4'd1;
                end else begin
                    match_d = match_q + 4'd1;
                end
                accept_s = (match_d == DEB_TARGET);
                expire_s = !accept_s && (samp_q == TMO_LAST);
                if (accept_s || expire_s) begin
                    // Timed-out sensors report active so downstream fails safe
                    shadow_d[idx_q] = accept_s ? cand_d : 1'b1;
                    tmo_d           = tmo_q | expire_s;
                    samp_d          = '0;
                    if (idx_q == 2'd3) begin
                        state_d   = S_DONE;
                        sensors_d = shadow_d;
                    end else begin
                        state_d  = S_SETTLE;
                        idx_d    = idx_q + 2'd1;
                        settle_d = 4'd0;
                    end
                end else begin
                    samp_d = samp_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, shadow and published outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            settle_q  <= 4'd0;
            match_q   <= 4'd0;
            cand_q    <= 1'b0;
            samp_q    <= '0;
            shadow_q  <= 4'd0;
            sensors_q <= 4'd0;
            tmo_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            settle_q  <= settle_d;
            match_q   <= match_d;
            cand_q    <= cand_d;
            samp_q    <= samp_d;
            shadow_q  <= shadow_d;
            sensors_q <= sensors_d;
            tmo_q     <= tmo_d;
            valid_q   <= (state_d == S_DONE);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign sel           = idx_q;
    assign sensors       = sensors_q;
    assign sensors_valid = valid_q;
    assign busy          = busy_q;
    assign timeout_flag  = tmo_q;

`ifdef SENSOR_ERROR_EN
    function automatic logic err_decode(input logic [3:0] v);
        return v[0] | (v[1] & (v[3] | v[2]));
    endfunction

    logic error_q;

    // Error decode loaded together with the published vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (state_d == S_DONE) begin
            error_q <= err_decode(sensors_d);
        end else begin
            error_q <= error_q;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_scan.sv
// Scoreboard bench for sensor_scan: per-sensor sample sequences are generated,
// a reference model derives acceptance time, value and timeout from the
// debounce rules, and a monitor compares every valid strobe against the queue.
module tb_sensor_scan;

    localparam int S = 4;
    localparam int D = 3;
    localparam int T = 16;

    typedef struct {
        logic [3:0] s;
        logic       t;
        logic       e;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_start = 1'b0;
    logic       sense_in = 1'b0;
    logic [1:0] sel;
    logic [3:0] sensors;
    logic       sensors_valid;
    logic       busy;
    logic       timeout_flag;
    logic       error;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic [3:0] last_s = 4'd0;

    sensor_scan #(.SETTLE_CYCLES(S), .DEBOUNCE_COUNT(D), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .scan_start(scan_start), .sense_in(sense_in),
        .sel(sel), .sensors(sensors), .sensors_valid(sensors_valid),
        .busy(busy), .timeout_flag(timeout_flag), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic err_ref(input logic [3:0] v);
`ifdef SENSOR_ERROR_EN
        return v[0] | (v[1] & (v[3] | v[2]));
`else
        return 1'b0;
`endif
    endfunction

    // Modes: 0 stable random, 1 alternating prefix then stable, 2 toggle always,
    // 3 random noise, 4 stable 1, 5 stable 0, 6 pattern 0,1,0,1 then 1.
    // Caller has just raised scan_start at a negedge; edge E0 follows.
    task automatic drive_scan(input bit keep, input int abort_at,
                              input int m0, input int m1, input int m2, input int m3);
        bit   seq [4][T];
        int   md [4];
        int   n [4];
        bit   v [4];
        bit   to [4];
        bit   vals[$];
        int   esel[$];
        int   c0, L, r;
        bit   b, b2;
        logic [3:0] es;
        exp_t e;
        md[0] = m0; md[1] = m1; md[2] = m2; md[3] = m3;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            b  = 1'($urandom_range(0, 1));
            b2 = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 6);
            for (int k = 0; k < T; k++) begin
                case (md[i])
                    0: seq[i][k] = b;
                    1: seq[i][k] = (k < r) ? (b ^ 1'(k % 2)) : b2;
                    2: seq[i][k] = b ^ 1'(k % 2);
                    3: seq[i][k] = 1'($urandom_range(0, 1));
                    4: seq[i][k] = 1'b1;
                    5: seq[i][k] = 1'b0;
                    default: seq[i][k] = (k < 4) ? 1'(k % 2) : 1'b1;
                endcase
            end
            // Reference: accept at first sample closing a run of D equal samples
            n[i] = T; v[i] = 1'b1; to[i] = 1'b1;
            for (int k = 0; k < T; k++) begin
                int run;
                run = 1;
                while (run <= k && seq[i][k - run] == seq[i][k]) run++;
                if (run >= D) begin
                    n[i] = k + 1; v[i] = seq[i][k]; to[i] = 1'b0;
                    break;
                end
            end
            for (int k = 0; k < S; k++) begin
                vals.push_back(1'($urandom_range(0, 1)));
                esel.push_back(i);
            end
            for (int k = 0; k < n[i]; k++) begin
                vals.push_back(seq[i][k]);
                esel.push_back(i);
            end
        end
        L = vals.size();
        es = {v[3], v[2], v[1], v[0]};
        e.s = es;
        e.t = to[0] | to[1] | to[2] | to[3];
        e.e = err_ref(es);
        e.cyc = c0 + 1 + L;
        if (abort_at < 0) sb.push_back(e);
        for (int j = 0; j <= L + 1; j++) begin
            @(negedge clk);
            if (j == abort_at) begin
                rst = 1'b1;
                scan_start = 1'b0;
                #1;
                chk("rst_sel", sel, 0);
                chk("rst_sensors", sensors, 0);
                chk("rst_valid", sensors_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_timeout", timeout_flag, 0);
                chk("rst_error", error, 0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            chk("sel", sel, (j < L) ? esel[j] : 3);
            chk("busy", busy, (j <= L) ? 1 : 0);
            sense_in   = (j < L) ? vals[j] : 1'($urandom_range(0, 1));
            scan_start = (j <= L) ? (keep | 1'($urandom_range(0, 1))) : keep;
        end
    endtask

    // Monitor: pops the scoreboard on every valid strobe; sensors must hold otherwise
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_s = 4'd0;
            end else if (sensors_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sensors", sensors, e.s);
                    chk("timeout_flag", timeout_flag, e.t);
                    chk("error", error, e.e);
                    chk("valid_cycle", cyc, e.cyc);
                    last_s = e.s;
                end
            end else begin
                chk("sensors_hold", sensors, last_s);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("init_sel", sel, 0);
        chk("init_sensors", sensors, 0);
        chk("init_valid", sensors_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_timeout", timeout_flag, 0);
        chk("init_error", error, 0);
        rst = 1'b0;
        // W=1 X=0 Y=1 Z=0 stable
        @(negedge clk); scan_start = 1'b1; drive_scan(1'b0, -1, 5, 4, 5, 4);
        // sensor 1 toggles 0,1,0,1 then stays 1
        @(negedge clk); scan_start = 1'b1; drive_scan(1'b0, -1, 4, 6, 4, 5);
        // sensor 3 toggles forever -> timeout, then a clean scan
        @(negedge clk); scan_start = 1'b1; drive_scan(1'b0, -1, 5, 5, 4, 2);
        @(negedge clk); scan_start = 1'b1; drive_scan(1'b0, -1, 5, 5, 5, 5);
        // error decode vectors 0110, 1100, 0001
        @(negedge clk); scan_start = 1'b1; drive_scan(1'b0, -1, 5, 4, 4, 5);
        @(negedge clk); scan_start = 1'b1; drive_scan(1'b0, -1, 5, 5, 4, 4);
        @(negedge clk); scan_start = 1'b1; drive_scan(1'b0, -1, 4, 5, 5, 5);
        // reset during SAMPLE of sensor 2 (stable inputs: j=18..20)
        @(negedge clk); scan_start = 1'b1; drive_scan(1'b0, 19, 4, 4, 4, 4);
        @(negedge clk); scan_start = 1'b1; drive_scan(1'b0, -1, 4, 5, 4, 5);
        // scan_start held high: back-to-back scans
        @(negedge clk); scan_start = 1'b1; drive_scan(1'b1, -1, 4, 4, 5, 5);
        drive_scan(1'b1, -1, 5, 4, 4, 4);
        drive_scan(1'b0, -1, 0, 0, 0, 0);
        // randomized scans
        for (int k = 0; k < 24; k++) begin
            bit kp;
            kp = (k < 23) && ($urandom_range(0, 3) == 0);
            if (!scan_start) begin
                @(negedge clk);
                scan_start = 1'b1;
            end
            drive_scan(kp, -1, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
        end
        repeat (4) @(negedge clk);
        chk("queue_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
